// File: rtl/cover_toggle_drain_scheduler_pkg.sv
// Shared types and helpers for the toggle-coverage drain scheduler.
package cover_pkg;

    localparam int COVER_IDX_W = 64;
    localparam int POP_MAX_W   = 256;
    localparam int POP_CNT_W   = 9;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

    // Counts set bits among the lowest 'width' bits of v; callers zero-extend
    // their vector to POP_MAX_W and pass their own width.
    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                      input int width);
        logic [POP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < width && v[i]) begin
                n = n + POP_CNT_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/cover_toggle_drain_scheduler_rr_picker.sv
// Combinational round-robin priority encoder: lowest request at or above
// ptr, otherwise wrap to the lowest request overall.
module cover_rr_picker #(
    parameter int WIDTH = 32,
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             gnt_valid,
    output logic [PW-1:0]    gnt_idx
);

    logic          hi_valid;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;

    // Scan downwards so the last hit written is the lowest index in each half.
    always_comb begin
        hi_valid  = 1'b0;
        hi_idx    = '0;
        gnt_valid = 1'b0;
        lo_idx    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_valid = 1'b1;
                lo_idx    = PW'(i);
                if (i >= int'(ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        gnt_idx = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/cover_toggle_drain_scheduler.sv
// Sticky toggle-coverage collector: records first-time hits and streams each
// one exactly once per epoch as an absolute cover index on a valid/ready port.
module cover_toggle_drain_scheduler
    import cover_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             enable,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output cover_idx_t       out_index,
    output logic [CW-1:0]    covered_count,
    output logic             all_covered,
    output logic             pending_any
);

    if (WIDTH < 2 || WIDTH > POP_MAX_W || COVER_INDEX < 0 ||
        COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_param_check
        $error("cover_toggle_drain_scheduler: bad WIDTH/COVER_INDEX/COVER_TOTAL");
    end

    logic [WIDTH-1:0]     hit_map;
    logic [WIDTH-1:0]     pend;
    logic [PW-1:0]        rr_ptr;
    logic [WIDTH-1:0]     new_hits;
    logic [POP_MAX_W-1:0] new_ext;
    logic [CW-1:0]        cnt_next;
    logic                 sel_valid;
    logic [PW-1:0]        sel_idx;
    logic                 load;
    logic [WIDTH-1:0]     sel_mask;

    cover_rr_picker #(.WIDTH(WIDTH)) u_picker (
        .req       (pend),
        .ptr       (rr_ptr),
        .gnt_valid (sel_valid),
        .gnt_idx   (sel_idx)
    );

    // First-time hits this cycle, their count, and the output-register load decision.
    always_comb begin
        new_hits = valid & ~hit_map & {WIDTH{enable}};
        new_ext  = '0;
        new_ext[WIDTH-1:0] = new_hits;
        cnt_next = covered_count + CW'(popcount(new_ext, WIDTH));
        load     = (!out_valid || out_ready) && sel_valid;
        sel_mask = '0;
        sel_mask[sel_idx] = load;
    end

    assign pending_any = |pend;

    // Capture, scheduling and output register; clear drops same-cycle hits and
    // only retires an output that is empty or being accepted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_map       <= '0;
            pend          <= '0;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else if (clear) begin
            hit_map       <= '0;
            pend          <= '0;
            rr_ptr        <= '0;
            covered_count <= '0;
            all_covered   <= 1'b0;
            if (!out_valid || out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            hit_map       <= hit_map | new_hits;
            pend          <= (pend & ~sel_mask) | new_hits;
            covered_count <= cnt_next;
            all_covered   <= (cnt_next == CW'(WIDTH));
            if (load) begin
                out_valid <= 1'b1;
                out_index <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel_idx);
                rr_ptr    <= (sel_idx == PW'(WIDTH - 1)) ? '0 : sel_idx + PW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cover_toggle_drain_scheduler.sv
// Directed bench with an index scoreboard: stimulus pushes the indices it
// expects, a negedge monitor pops and compares on every accepted transfer.
module tb_cover_toggle_drain_scheduler;

    localparam int W  = 32;
    localparam int CI = 100;

    logic        clock;
    logic        reset;
    logic [W-1:0] valid;
    logic        enable;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_index;
    logic [5:0]  covered_count;
    logic        all_covered;
    logic        pending_any;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    cover_toggle_drain_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(10906)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .enable        (enable),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered),
        .pending_any   (pending_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    // Scoreboard monitor: a transfer completes at the next edge when valid&&ready.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_index", out_index, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("stream_index", out_index, 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b0; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
        cyc(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_covered", covered_count, 0);
        chk("rst_all_covered", all_covered, 0);
        chk("rst_pending", pending_any, 0);
        reset = 1'b1;
        cyc();

        // Two hits: 100 then 102 back-to-back, first one visible two edges later.
        exp_q.push_back(100); exp_q.push_back(102);
        valid = 32'h0000_0005;
        cyc();
        valid = '0;
        chk("t1_latency_ov", out_valid, 0);
        chk("t1_covered", covered_count, 2);
        chk("t1_pending", pending_any, 1);
        cyc();
        chk("t1_first_ov", out_valid, 1);
        chk("t1_first_idx", out_index, 100);
        cyc();
        chk("t1_second_idx", out_index, 102);
        cyc();
        chk("t1_drop_ov", out_valid, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // Repeat hits are ignored.
        valid = 32'h0000_0005;
        cyc();
        valid = '0;
        cyc(3);
        chk("t2_ov", out_valid, 0);
        chk("t2_covered", covered_count, 2);
        chk("t2_pending", pending_any, 0);

        // Full vector under backpressure, fresh epoch.
        do_clear();
        chk("t3_clr_covered", covered_count, 0);
        out_ready = 1'b0;
        for (int i = 0; i < W; i++) exp_q.push_back(CI + i);
        valid = 32'hFFFF_FFFF;
        cyc();
        valid = '0;
        chk("t3_covered", covered_count, 32);
        chk("t3_all_covered", all_covered, 1);
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_ov", out_valid, 1);
            chk("t3_hold_idx", out_index, 100);
            cyc();
        end
        out_ready = 1'b1;
        cyc(34);
        chk("t3_drain_ov", out_valid, 0);
        chk("t3_q_empty", exp_q.size(), 0);

        // Round-robin: after bit 5, bits 2 and 9 arrive together -> 109 before 102.
        do_clear();
        exp_q.push_back(105);
        valid = 32'h0000_0020;
        cyc();
        valid = '0;
        cyc(3);
        exp_q.push_back(109); exp_q.push_back(102);
        valid = 32'h0000_0204;
        cyc();
        valid = '0;
        cyc(4);
        chk("t4_q_empty", exp_q.size(), 0);

        // clear with a held output and pending bits 3/4.
        do_clear();
        out_ready = 1'b0;
        exp_q.push_back(101);
        valid = 32'h0000_0002;
        cyc();
        valid = 32'h0000_0018;
        cyc();
        valid = '0;
        chk("t5_pre_ov", out_valid, 1);
        chk("t5_pre_pending", pending_any, 1);
        do_clear();
        chk("t5_held_ov", out_valid, 1);
        chk("t5_held_idx", out_index, 101);
        chk("t5_covered", covered_count, 0);
        chk("t5_pending", pending_any, 0);
        out_ready = 1'b1;
        cyc(4);
        chk("t5_after_ov", out_valid, 0);
        exp_q.push_back(100);
        valid = 32'h0000_0001;
        cyc();
        valid = '0;
        cyc(3);
        chk("t5_reemit_covered", covered_count, 1);
        chk("t5_q_empty", exp_q.size(), 0);

        // Reset in the middle of a drain.
        do_clear();
        exp_q.push_back(100); exp_q.push_back(101);
        valid = 32'h0000_00FF;
        cyc();
        valid = '0;
        cyc(3);
        reset = 1'b0;
        cyc();
        chk("t6_rst_ov", out_valid, 0);
        chk("t6_rst_idx", out_index, 0);
        chk("t6_rst_covered", covered_count, 0);
        chk("t6_rst_pending", pending_any, 0);
        reset = 1'b1;
        cyc();
        chk("t6_q_empty", exp_q.size(), 0);

        // enable=0 blocks capture.
        exp_q.push_back(131);
        valid = 32'h8000_0000;
        cyc();
        valid = '0;
        cyc(3);
        enable = 1'b0;
        valid = 32'h0000_00FF;
        cyc(2);
        chk("t7_ov", out_valid, 0);
        chk("t7_covered", covered_count, 1);
        chk("t7_pending", pending_any, 0);
        valid = '0;
        enable = 1'b1;
        cyc(3);
        chk("t7_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
